ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/k_and_s_pkg.sv | 20 ++
 rtl/ram_array.sv | 33 +++
 rtl/ram_responder.sv | 148 ++++++++++++++
 tb/tb_ram_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the processor-side RAM responder.
package k_and_s_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 16;
  localparam int unsigned RAM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ram_state_t;

  // True when a word address falls inside an array of the given depth.
  function automatic logic addr_in_range(input logic [RAM_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x 16 storage: combinational read, synchronous write; contents are never reset.
module ram_array
  import k_and_s_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] waddr,
  input  logic [RAM_DATA_W-1:0] wdata,
  input  logic [RAM_ADDR_W-1:0] raddr,
  output logic [RAM_DATA_W-1:0] rdata_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RAM_DATA_W-1:0] mem [DEPTH];
  logic                  rd_ok;
  logic                  wr_ok;

  // Out-of-range addresses read as zero and never write.
  always_comb begin
    rd_ok   = addr_in_range(raddr, DEPTH);
    wr_ok   = addr_in_range(waddr, DEPTH);
    rdata_c = '0;
    if (rd_ok) rdata_c = mem[raddr[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (we && wr_ok) mem[waddr[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/ram_responder.sv
// Single-port RAM responder with ack handshake; the WAIT state and its
// countdown exist only when RAM_WAIT_STATES_EN is defined.
module ram_responder
  import k_and_s_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  write_en,
  input  logic [RAM_ADDR_W-1:0] ram_addr,
  input  logic [RAM_DATA_W-1:0] data_in,
  output logic [RAM_DATA_W-1:0] data_out,
  output logic                  ack,
  output logic                  busy,
  output logic                  addr_err
);

  if (DEPTH == 0 || DEPTH > 32) begin : g_bad_depth
    $error("ram_responder: DEPTH must be 1..32");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("ram_responder: WAIT_STATES must be 0..15");
  end

  ram_state_t            state_q, state_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [RAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [RAM_DATA_W-1:0] data_out_q, data_out_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  addr_err_q, addr_err_d;

  logic [RAM_ADDR_W-1:0] acc_addr;
  logic                  acc_we;
  logic [RAM_DATA_W-1:0] acc_wdata;
  logic                  acc_in_range;
  logic                  enter_resp;
  logic                  arr_we;
  logic [RAM_DATA_W-1:0] arr_rdata;

`ifdef RAM_WAIT_STATES_EN
  localparam logic [RAM_CNT_W-1:0] WAIT_LOAD = RAM_CNT_W'(WAIT_STATES - 1);
  logic [RAM_CNT_W-1:0] cnt_q, cnt_d;
`endif

  ram_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we      (arr_we),
    .waddr   (acc_addr),
    .wdata   (acc_wdata),
    .raddr   (acc_addr),
    .rdata_c (arr_rdata)
  );

  // In IDLE the live inputs feed the array so a zero-wait access resolves on the accept edge.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
`ifdef RAM_WAIT_STATES_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        acc_addr  = ram_addr;
        acc_we    = write_en;
        acc_wdata = data_in;
        if (req) begin
          addr_d  = ram_addr;
          we_d    = write_en;
          wdata_d = data_in;
`ifdef RAM_WAIT_STATES_EN
          if (WAIT_STATES != 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
`else
          state_d = RESP;
`endif
        end
      end
`ifdef RAM_WAIT_STATES_EN
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - RAM_CNT_W'(1);
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enter_resp   = (state_d == RESP) && (state_q != RESP);
    acc_in_range = addr_in_range(acc_addr, DEPTH);
    arr_we       = enter_resp && acc_we && acc_in_range && !rst;

    data_out_d = data_out_q;
    if (enter_resp && !acc_we) data_out_d = acc_in_range ? arr_rdata : '0;

    ack_d      = (state_d == RESP);
    busy_d     = (state_d != IDLE);
    addr_err_d = (state_d == RESP) && !acc_in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
`ifdef RAM_WAIT_STATES_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
`ifdef RAM_WAIT_STATES_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder (DEPTH=16, WAIT_STATES=2); latency follows RAM_WAIT_STATES_EN.
module tb_ram_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WS    = 2;
`ifdef RAM_WAIT_STATES_EN
  localparam int LAT = WS;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req;
  logic        write_en;
  logic [4:0]  ram_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        ack;
  logic        busy;
  logic        addr_err;

  int          vectors;
  int          miscompares;
  int          cyc;
  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mem [DEPTH];
  logic [15:0] last_rd;

  ram_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .write_en (write_en),
    .ram_addr (ram_addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .busy     (busy),
    .addr_err (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Called at the negedge where req is driven; the accept edge is the next posedge.
  function automatic void push_exp(input logic we, input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    e.cyc = cyc + 1 + LAT;
    e.err = (int'(a) >= int'(DEPTH));
    if (we) begin
      if (!e.err) mem[int'(a)] = d;
      e.data = last_rd;
      e.tag  = $sformatf("wr%0d", a);
    end else begin
      e.data  = e.err ? 16'h0000 : mem[int'(a)];
      last_rd = e.data;
      e.tag   = $sformatf("rd%0d", a);
    end
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && ack === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'(0));
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.tag, "_data"}, 32'(data_out), 32'(mon_e.data));
        chk({mon_e.tag, "_err"}, 32'(addr_err), 32'(mon_e.err));
        chk({mon_e.tag, "_ack_cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic access(input logic we, input logic [4:0] a, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("wait_idle");
    req      = 1'b1;
    write_en = we;
    ram_addr = a;
    data_in  = d;
    push_exp(we, a, d);
    @(negedge clk);
    req      = 1'b0;
    write_en = 1'($urandom);
    ram_addr = 5'($urandom);
    data_in  = 16'($urandom);
    n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("wait_ack");
  endtask

  initial begin : watchdog
    #500000;
    $error("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench stuck");
  end

  initial begin : stim
    logic [4:0] addrs [3];
    int issued, acked, n;
    bit pending, gap;

    vectors     = 0;
    miscompares = 0;
    last_rd     = 16'h0000;
    rst = 1'b1; req = 1'b0; write_en = 1'b0; ram_addr = '0; data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_addr_err", 32'(addr_err), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    rst = 1'b0;

    for (int a = 0; a < int'(DEPTH); a++)
      access(1'b1, 5'(a), 16'(16'h1111 * a) ^ 16'h5A00);

    access(1'b0, 5'd3, 16'h0000);
    access(1'b1, 5'd7, 16'hA5C3);
    access(1'b0, 5'd7, 16'h0000);

    // Out-of-range write must be dropped and every word left intact.
    access(1'b1, 5'd20, 16'hFFFF);
    access(1'b0, 5'd20, 16'h0000);
    for (int a = 0; a < int'(DEPTH); a++) access(1'b0, 5'(a), 16'h0000);
    access(1'b0, 5'd16, 16'h0000);
    access(1'b0, 5'd31, 16'h0000);

    // req held high across three reads, junk on the bus while busy.
    addrs   = '{5'd1, 5'd2, 5'd3};
    issued  = 0;
    acked   = 0;
    n       = 0;
    pending = 1'b0;
    gap     = 1'b0;
    @(negedge clk);
    while (acked < 3 && n < 100) begin
      if (gap) begin
        chk("held_idle_gap", 32'(busy), 32'(0));
        gap = 1'b0;
      end
      if (!pending && busy === 1'b0 && issued < 3) begin
        req      = 1'b1;
        write_en = 1'b0;
        ram_addr = addrs[issued];
        data_in  = 16'($urandom);
        push_exp(1'b0, addrs[issued], 16'h0000);
        issued++;
        pending = 1'b1;
      end else begin
        write_en = 1'($urandom);
        ram_addr = 5'($urandom);
        data_in  = 16'($urandom);
        if (ack === 1'b1) begin
          pending = 1'b0;
          acked++;
          gap = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    write_en = 1'b0;
    if (n >= 100) fail_now("held_req");
    chk("held_idle_gap_last", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    for (int a = 0; a < int'(DEPTH); a++) access(1'b0, 5'(a), 16'h0000);

`ifdef RAM_WAIT_STATES_EN
    // Reset lands in WAIT: the write to addr 5 must be aborted with no ack.
    @(negedge clk);
    req = 1'b1; write_en = 1'b1; ram_addr = 5'd5; data_in = 16'h1234;
    @(negedge clk);
    chk("abort_busy_in_wait", 32'(busy), 32'(1));
    req = 1'b0; write_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`else
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ack", 32'(ack), 32'(0));
    chk("abort_data_out", 32'(data_out), 32'(0));
    chk("abort_addr_err", 32'(addr_err), 32'(0));
    last_rd = 16'h0000;
    repeat (4) @(negedge clk);
    access(1'b1, 5'd9, 16'hBEEF);
    access(1'b0, 5'd5, 16'h0000);
    access(1'b0, 5'd15, 16'h0000);
    access(1'b0, 5'd9, 16'h0000);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
